bus_transfer_seq: RTL and testbench



---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_transfer_seq_if.sv | 28 ++
 rtl/xfer_fifo.sv | 54 +++++
 rtl/bus_transfer_seq.sv | 129 ++++++++++++
 tb/tb_bus_transfer_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the register-bus transfer engine: sizes, endpoint
// indices and FSM state encoding.
package bus_pkg;

    localparam int DATA_W = 32;
    localparam int NSRC   = 24;
    localparam int IDX_W  = 5;
    localparam int QDEPTH = 4;

    typedef enum logic [IDX_W-1:0] {
        R0, R1, R2, R3, R4, R5, R6, R7,
        R8, R9, R10, R11, R12, R13, R14, R15,
        PC, HI, LO, IR, Y, ZHI, ZLOW, MDR
    } endpoint_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_transfer_seq_if.sv
// Request handshake plus register-bus signals between the control unit
// (master) and the transfer engine (slave).
interface bus_transfer_seq_if #(
    parameter int DATA_W = bus_pkg::DATA_W,
    parameter int NSRC   = bus_pkg::NSRC,
    parameter int IDX_W  = bus_pkg::IDX_W
);
    logic                   req_valid;
    logic                   req_ready;
    logic [IDX_W-1:0]       req_src;
    logic [IDX_W-1:0]       req_dst;
    logic [NSRC*DATA_W-1:0] src_data;
    logic [DATA_W-1:0]      bus_data;
    logic [NSRC-1:0]        src_out;
    logic [NSRC-1:0]        dst_in;
    logic                   busy;
    logic                   err;

    modport master (
        output req_valid, req_src, req_dst, src_data,
        input  req_ready, bus_data, src_out, dst_in, busy, err
    );

    modport slave (
        input  req_valid, req_src, req_dst, src_data,
        output req_ready, bus_data, src_out, dst_in, busy, err
    );
endinterface

// File: rtl/xfer_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full when MSBs differ and the
// index bits match. Read data is the head entry, valid whenever !empty.
module xfer_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // NOTE: non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_transfer_seq.sv
// Register-bus transfer engine: queues (src, dst) requests, drives the source
// onto the bus for a DRIVE cycle, then pulses the destination load in LOAD.
module bus_transfer_seq #(
    parameter int DATA_W = bus_pkg::DATA_W,
    parameter int NSRC   = bus_pkg::NSRC,
    parameter int IDX_W  = bus_pkg::IDX_W,
    parameter int QDEPTH = bus_pkg::QDEPTH
) (
    input logic              clk,
    input logic              clr,
    bus_transfer_seq_if.slave bif
);
    import bus_pkg::*;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*IDX_W-1:0]   head;
    logic [IDX_W-1:0]     head_src, head_dst;
    logic                 head_ok, take;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cur_src_q, cur_src_d;
    logic [IDX_W-1:0]     cur_dst_q, cur_dst_d;
    logic [NSRC-1:0]      src_out_q, src_out_d;
    logic [NSRC-1:0]      dst_in_q, dst_in_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    bus_mux;

    // Out-of-range indices decode to all-zero, keeping the selects one-hot or zero.
    function automatic logic [NSRC-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NSRC-1:0] oh;
        oh = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(idx) == i) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign bif.req_ready = !fifo_full && !clr;
    assign fifo_push     = bif.req_valid && bif.req_ready;

    xfer_fifo #(
        .WIDTH(2*IDX_W),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({bif.req_src, bif.req_dst}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_src, head_dst} = head;
    assign head_ok = (int'(head_src) < NSRC) && (int'(head_dst) < NSRC);

    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        src_out_d = '0;
        dst_in_d  = '0;
        err_d     = 1'b0;
        fifo_pop  = 1'b0;
        take      = 1'b0;

        case (state_q)
            IDLE:  take = !fifo_empty;
            DRIVE: begin
                state_d   = LOAD;
                src_out_d = onehot(cur_src_q);
                dst_in_d  = onehot(cur_dst_q);
            end
            LOAD: begin
                take = !fifo_empty;
                if (fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A popped request with a bad index is dropped: err pulse, no bus activity.
        if (take) begin
            fifo_pop  = 1'b1;
            cur_src_d = head_src;
            cur_dst_d = head_dst;
            if (head_ok) begin
                state_d   = DRIVE;
                src_out_d = onehot(head_src);
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            src_out_q <= '0;
            dst_in_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            src_out_q <= src_out_d;
            dst_in_q  <= dst_in_d;
            err_q     <= err_d;
        end
    end

    // AND-OR mux under the registered one-hot select; zero when nothing drives.
    always_comb begin
        bus_mux = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_out_q[i]) bus_mux = bus_mux | bif.src_data[i*DATA_W +: DATA_W];
        end
    end

    assign bif.bus_data = bus_mux;
    assign bif.src_out  = src_out_q;
    assign bif.dst_in   = dst_in_q;
    assign bif.err      = err_q;
    assign bif.busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bus_transfer_seq.sv
// Directed bench for bus_transfer_seq: reset, single transfer, back-to-back,
// full queue, invalid index and clear during LOAD.
module tb_bus_transfer_seq;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    bus_transfer_seq_if bif ();

    bus_transfer_seq dut (
        .clk (clk),
        .clr (clr),
        .bif (bif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] so;
        logic [23:0] di;
        logic [31:0] bus;
    } xfer_t;

    // Destination loads actually committed (dst_in high on an edge without clr).
    xfer_t log_q[$];
    always @(negedge clk) begin
        if (!clr && bif.dst_in != '0)
            log_q.push_back('{so: bif.src_out, di: bif.dst_in, bus: bif.bus_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] val(input int s);
        return (s == 3) ? 32'hDEADBEEF : 32'hC0DE_0000 + 32'(s * 'h111);
    endfunction

    function automatic logic [23:0] oh(input int s);
        return 24'(1) << s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input int s, input int d);
        bif.req_valid = v;
        bif.req_src   = 5'(s);
        bif.req_dst   = 5'(d);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (bif.busy && n < 60) begin
            tick();
            n++;
        end
        check(tag, bif.busy, 1'b0);
    endtask

    int b2s[4] = '{int'(R1), int'(PC), int'(ZLOW), int'(Y)};
    int b2d[4] = '{int'(R2), int'(MDR), int'(R0), int'(Y)};
    int fs[8]  = '{0, 4, 8, 12, 16, 17, 18, 19};
    int fd[8]  = '{1, 5, 9, 13, 21, 22, 10, 11};

    initial begin
        for (int i = 0; i < 24; i++) bif.src_data[i*32 +: 32] = val(i);
        set_req(1'b0, 0, 0);
        clr = 1'b1;

        // Reset
        tick();
        tick();
        check("ready_during_clr", bif.req_ready, 1'b0);
        clr = 1'b0;
        #1;
        check("rst_ready", bif.req_ready, 1'b1);
        check("rst_bus", bif.bus_data, 32'h0);
        check("rst_src_out", bif.src_out, 24'h0);
        check("rst_dst_in", bif.dst_in, 24'h0);
        check("rst_err", bif.err, 1'b0);
        check("rst_busy", bif.busy, 1'b0);

        // Single transfer R3 -> R7, accepted at edge k
        set_req(1'b1, R3, R7);
        tick();
        set_req(1'b0, 0, 0);
        check("t1_busy", bif.busy, 1'b1);
        check("t1_idle_src", bif.src_out, 24'h0);
        tick();
        check("t1_drive_src", bif.src_out, oh(3));
        check("t1_drive_bus", bif.bus_data, 32'hDEADBEEF);
        check("t1_drive_dst", bif.dst_in, 24'h0);
        tick();
        check("t1_load_src", bif.src_out, oh(3));
        check("t1_load_bus", bif.bus_data, 32'hDEADBEEF);
        check("t1_load_dst", bif.dst_in, oh(7));
        tick();
        check("t1_after_dst", bif.dst_in, 24'h0);
        check("t1_after_bus", bif.bus_data, 32'h0);
        check("t1_after_busy", bif.busy, 1'b0);

        // Back-to-back: four requests pushed on consecutive edges
        set_req(1'b1, b2s[0], b2d[0]);
        tick();
        for (int p = 0; p < 8; p++) begin
            if (p < 3) set_req(1'b1, b2s[p+1], b2d[p+1]);
            else       bif.req_valid = 1'b0;
            tick();
            check($sformatf("b2b_src_%0d", p), bif.src_out, oh(b2s[p/2]));
            check($sformatf("b2b_bus_%0d", p), bif.bus_data, val(b2s[p/2]));
            check($sformatf("b2b_dst_%0d", p), bif.dst_in, (p % 2 == 1) ? oh(b2d[p/2]) : 24'h0);
        end
        tick();
        check("b2b_idle_busy", bif.busy, 1'b0);
        check("b2b_idle_src", bif.src_out, 24'h0);

        // Full queue: valid held high, next request offered only after acceptance
        log_q.delete();
        begin
            int sent = 0;
            for (int e = 0; e < 9; e++) begin
                set_req(1'b1, fs[sent], fd[sent]);
                check($sformatf("full_ready_%0d", e), bif.req_ready, (e == 7) ? 1'b0 : 1'b1);
                if (bif.req_ready) sent++;
                tick();
            end
            bif.req_valid = 1'b0;
            check("full_sent", 64'(sent), 64'd8);
        end
        drain("full_drain");
        check("full_count", 64'(log_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            check($sformatf("full_sel_%0d", i), {log_q[i].so, log_q[i].di}, {oh(fs[i]), oh(fd[i])});
            check($sformatf("full_bus_%0d", i), log_q[i].bus, val(fs[i]));
        end

        // Invalid source index followed by a valid request
        log_q.delete();
        set_req(1'b1, 25, R1);
        tick();
        set_req(1'b1, R2, R4);
        tick();
        bif.req_valid = 1'b0;
        check("inv_err", bif.err, 1'b1);
        check("inv_src", bif.src_out, 24'h0);
        check("inv_dst", bif.dst_in, 24'h0);
        tick();
        check("inv_err_clear", bif.err, 1'b0);
        check("inv_next_src", bif.src_out, oh(2));
        check("inv_next_bus", bif.bus_data, val(2));
        tick();
        check("inv_next_dst", bif.dst_in, oh(4));
        drain("inv_drain");
        check("inv_count", 64'(log_q.size()), 64'd1);

        // Clear asserted during LOAD of R5 -> R6 with two requests queued
        log_q.delete();
        set_req(1'b1, R5, R6);
        tick();
        set_req(1'b1, R8, R9);
        tick();
        check("clr_drive_src", bif.src_out, oh(5));
        set_req(1'b1, R10, R11);
        tick();
        check("clr_load_dst", bif.dst_in, oh(6));
        bif.req_valid = 1'b0;
        clr = 1'b1;
        tick();
        check("clr_dst", bif.dst_in, 24'h0);
        check("clr_src", bif.src_out, 24'h0);
        check("clr_busy", bif.busy, 1'b0);
        check("clr_ready", bif.req_ready, 1'b0);
        clr = 1'b0;
        repeat (6) tick();
        check("clr_no_xfer", 64'(log_q.size()), 64'd0);
        check("clr_still_idle", bif.busy, 1'b0);
        check("clr_src_quiet", bif.src_out, 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
